// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM state
// encodings, the default reset PC and a branch-target alignment helper.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'hD503201F;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Instructions are word aligned, so the low two target bits carry no meaning.
  function automatic logic [63:0] align_target(input logic [63:0] target);
    return {target[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter: 64-bit register with asynchronous reset to RESET_PC and a
// load enable selecting the next value.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        i_load,
  input  logic [63:0] i_next,
  output logic [63:0] o_pc
);

  logic [63:0] r_pc;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC to instruction memory and captures the
// returned word into the IF/ID register, handling stall, redirect and halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 160
) (
  input  logic         CLK,
  input  logic         Reset,
  output logic [63:0]  Address,
  input  logic [31:0]  Data,
  input  logic         Stall,
  input  logic         BranchTaken,
  input  logic [63:0]  BranchTarget,
  output logic [63:0]  IFID_PC,
  output logic [31:0]  IFID_Instr,
  output logic         IFID_Valid,
  output logic         Halted,
  output logic [31:0]  FetchCount,
  output fetch_state_e DbgState
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

  fetch_state_e r_state, w_state_next;

  logic [63:0] w_pc;
  logic        w_pc_load;
  logic [63:0] w_pc_next;

  logic [63:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;

  logic        w_ifid_load;
  logic        w_ifid_valid_next;
  logic [31:0] w_ifid_instr_next;
  logic        w_count_inc;

  logic [63:0] w_branch_target;
  logic        w_branch_in_range;
  logic        w_pc_out_of_range;

  assign w_branch_target   = align_target(BranchTarget);
  assign w_branch_in_range = (w_branch_target < IMEM_LIMIT);
  assign w_pc_out_of_range = (w_pc >= IMEM_LIMIT);

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .CLK    (CLK),
    .Reset  (Reset),
    .i_load (w_pc_load),
    .i_next (w_pc_next),
    .o_pc   (w_pc)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Redirect outranks stall; a bubble always records the PC it replaces.
  always_comb begin
    w_state_next      = r_state;
    w_pc_load         = 1'b0;
    w_pc_next         = w_pc;
    w_ifid_load       = 1'b0;
    w_ifid_valid_next = 1'b0;
    w_ifid_instr_next = NOP_INSTR;
    w_count_inc       = 1'b0;

    unique case (r_state)
      ST_BOOT: begin
        w_ifid_load  = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (BranchTaken) begin
          w_pc_load   = 1'b1;
          w_pc_next   = w_branch_target;
          w_ifid_load = 1'b1;
        end else if (Stall) begin
          w_ifid_load = 1'b0;
        end else if (w_pc_out_of_range) begin
          w_ifid_load  = 1'b1;
          w_state_next = ST_HALTED;
        end else begin
          w_ifid_load       = 1'b1;
          w_ifid_valid_next = 1'b1;
          w_ifid_instr_next = Data;
          w_pc_load         = 1'b1;
          w_pc_next         = w_pc + 64'd4;
          w_count_inc       = 1'b1;
        end
      end
      ST_HALTED: begin
        w_ifid_load = 1'b1;
        if (BranchTaken && w_branch_in_range) begin
          w_pc_load    = 1'b1;
          w_pc_next    = w_branch_target;
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ifid_pc    <= 64'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_ifid_pc    <= w_pc;
      r_ifid_instr <= w_ifid_instr_next;
      r_ifid_valid <= w_ifid_valid_next;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_fetch_count <= 32'h0;
    end else if (w_count_inc && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign Address    = w_pc;
  assign IFID_PC    = r_ifid_pc;
  assign IFID_Instr = r_ifid_instr;
  assign IFID_Valid = r_ifid_valid;
  assign Halted     = (r_state == ST_HALTED);
  assign FetchCount = r_fetch_count;
  assign DbgState   = r_state;

endmodule
